// File: rtl/program_counter_pkg.sv
// Shared core definitions for the fetch path: address width, reset vector and address type.
package program_counter_pkg;

    localparam int PC_WIDTH = 16;

    typedef logic [PC_WIDTH-1:0] addr_t;

    localparam addr_t RESET_ADDR = 16'h0000;
    localparam addr_t PC_INCR    = 16'h0001;

    // Next-PC selection without reset: a stall wins over a branch, and a branch wins over increment.
    function automatic addr_t pc_next_mux(
        input addr_t pc,
        input logic  mem_ready,
        input logic  branch_en,
        input addr_t branch_addr,
        input addr_t incr
    );
        addr_t nxt;
        nxt = pc;
        if (mem_ready) begin
            nxt = branch_en ? branch_addr : addr_t'(pc + incr);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/program_counter.sv
// Instruction-fetch program counter: a next-PC mux feeding a single register.
module program_counter
    import program_counter_pkg::*;
#(
    parameter addr_t RST_VECTOR = RESET_ADDR,
    parameter addr_t INCR       = PC_INCR
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  mem_ready,
    input  logic  branch_en,
    input  addr_t branch_addr,
    output addr_t pc_current
);

    addr_t pc_q;
    addr_t pc_d;

    always_comb begin
        pc_d = pc_next_mux(pc_q, mem_ready, branch_en, branch_addr, INCR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RST_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Output comes straight off the flop so the memory address path sees no input-to-output timing.
    assign pc_current = pc_q;

endmodule

// File: tb/tb_program_counter.sv
// Scoreboard bench for program_counter: the driver pushes expected PCs, the monitor pops and compares.
module tb_program_counter;
    import program_counter_pkg::*;

    logic  clk = 1'b0;
    logic  rst = 1'b0;
    logic  mem_ready = 1'b0;
    logic  branch_en = 1'b0;
    addr_t branch_addr = '0;
    addr_t pc_current;

    program_counter dut (
        .clk        (clk),
        .rst        (rst),
        .mem_ready  (mem_ready),
        .branch_en  (branch_en),
        .branch_addr(branch_addr),
        .pc_current (pc_current)
    );

    always #5 clk = ~clk;

    typedef struct {
        string   name;
        int      value;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   model_pc = 0;
    bit   done     = 1'b0;

    // Reference model: the PC as a plain integer in [0, 65536).
    task automatic step(input bit r, input bit m, input bit b, input int a, input string name);
        exp_t e;
        @(negedge clk);
        rst         = r;
        mem_ready   = m;
        branch_en   = b;
        branch_addr = addr_t'(a);
        if (r)       model_pc = 0;
        else if (!m) model_pc = model_pc;
        else if (b)  model_pc = a % 65536;
        else         model_pc = (model_pc + 1) % 65536;
        e.name  = name;
        e.value = model_pc;
        exp_q.push_back(e);
    endtask

    // Monitor: one expected value per edge, sampled 1 time unit after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (int'(pc_current) != e.value) begin
                    n_fail++;
                    $display("FAIL %s: pc_current=0x%04h expected=0x%04h", e.name, pc_current, e.value[15:0]);
                end
            end
        end
    end

    initial begin
        int wait_cycles;
        // Directed scenarios
        step(1, 1, 0, 0,      "reset");
        step(0, 1, 0, 0,      "incr_1");
        step(0, 1, 0, 0,      "incr_2");
        step(0, 1, 1, 'hA000, "branch_a000");
        step(0, 0, 0, 0,      "stall_hold_1");
        step(0, 0, 0, 0,      "stall_hold_2");
        step(0, 1, 0, 0,      "resume_a001");
        step(0, 0, 1, 'h1234, "stall_ignores_branch");
        step(0, 0, 1, 'h1234, "stall_ignores_branch_2");
        step(0, 1, 1, 'h1234, "held_branch_taken");
        step(0, 1, 1, 'hFFFF, "branch_ffff");
        step(0, 1, 0, 0,      "wrap_to_0000");
        step(0, 1, 0, 0,      "after_wrap");
        step(0, 1, 1, 'h5555, "branch_5555");
        step(1, 0, 1, 'h7777, "reset_mid_stall");
        step(0, 1, 0, 0,      "restart_after_reset");
        step(0, 1, 1, 'h0003, "branch_odd_verbatim");
        step(1, 1, 1, 'h9999, "reset_over_branch");

        // Randomized traffic with occasional resets and stalls
        for (int i = 0; i < 2000; i++) begin
            bit r, m, b;
            int a;
            r = ($urandom_range(0, 49) == 0);
            m = ($urandom_range(0, 3) != 0);
            b = ($urandom_range(0, 4) == 0);
            a = (i % 97 == 0) ? 'hFFFF : int'($urandom_range(0, 65535));
            step(r, m, b, a, "random");
        end

        // Drain: bounded wait for the monitor to consume every expectation
        wait_cycles = 0;
        while (exp_q.size() != 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d expectations left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
